exu_seq: RTL and testbench
==========================

# exu_seq

Sequential, parametrised execute unit for the NPC core. It accepts one decoded operation per valid/ready handshake, selects operands, and computes either a single-cycle ALU result or an iterative RV32M multiply/divide result. The result is held in an output register until the consumer takes it. It sits between IDU and LSU/WBU and replaces the purely combinational execute stage in the multi-cycle datapath.

## Interface
- XLEN, 32: datapath width in bits; any value ≥ 8 that is a power of two.
- SHW, $clog2(XLEN): shift-amount width.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit can accept an operation.
- alu_srca  in  2  operand A select: 00 data_reg1, 01 zero, 10 pc_val, 11 zero.
- alu_srcb  in  2  operand B select: 00 data_reg2, 01 ext_imm, 10 data_reg2 masked to its low SHW bits, 11 zero.
- alu_ctrl  in  4  ALU op: 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and; 10–15 give 0.
- md_en  in  1  perform an M-extension op instead of an ALU op; operands are always data_reg1 and data_reg2.
- md_op  in  3  0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu.
- data_reg1, data_reg2, ext_imm, pc_val  in  XLEN  source values.
- out_valid  out  1  alu_res is valid.
- out_ready  in  1  consumer takes the result.
- alu_res  out  XLEN  registered result.

## Operation
- FSM states: IDLE, BUSY, DONE. in_ready = (state==IDLE) && !rst.
- Accept when in_valid && in_ready. All inputs are captured on the accept edge; later changes have no effect.
- ALU op, or an M-extension special case: the result is computed from the captured operands and written to alu_res; go IDLE→DONE.
- M-extension op: go IDLE→BUSY. Iteration counter is loaded with XLEN and decrements once per cycle.
  - Multiply: shift-add on absolute values per md_op signedness, using a 2·XLEN product register. mul returns the low half. mulh, mulhsu and mulhu return the high half. A sign correction is applied at completion.
  - Divide: restoring divider on magnitudes. Quotient sign = sign(a) XOR sign(b). Remainder takes the sign of the dividend.
  - When the counter reaches 0: write alu_res and go BUSY→DONE.
- M-extension special cases bypass BUSY:
  - Divisor 0: div/divu return all-ones; rem/remu return the dividend.
  - Signed overflow (most negative value / −1): div returns the most negative value; rem returns 0.
- DONE: out_valid=1 and alu_res is held stable. On out_ready go DONE→IDLE.
- Arithmetic wraps modulo 2^XLEN.
- slt/sltu return 0 or 1, zero-extended.
- Shifts use only the low SHW bits of operand B.

## Timing
- Reset values: state IDLE, out_valid 0, alu_res 0, counter 0, in_ready 0 while rst is high.
- Reset mid-BUSY or mid-DONE aborts the operation. No result is emitted and in_ready rises the cycle after rst falls.
- Latency, with accept at edge T:
  - ALU op or special case: out_valid high from T+1.
  - Multiply or divide: out_valid high from T+XLEN+1.
- Throughput: in_ready is low in DONE, so at most one operation every 2 cycles; the minimum gap is one IDLE cycle.
- out_valid stays high for as many cycles as out_ready stays low, with alu_res unchanged.
- out_ready while not in DONE is ignored.

## Configuration
- EXU_MDU_EN defined: the multiply/divide datapath, counter and BUSY state are compiled in, as described above.
- EXU_MDU_EN undefined: no MDU logic is built and md_op is ignored. An accepted op with md_en=1 completes like an ALU op (DONE at T+1) with alu_res=0.

## Test plan
- Reset, then ALU add with srca=00, srcb=01, data_reg1=5, ext_imm=0xFFFFFFFF -> out_valid at T+1, alu_res=4. With out_ready held low for 3 cycles, alu_res stays 4 and in_ready stays 0.
- Shift with srcb=10, data_reg2=0x23, alu_ctrl=7, data_reg1=0x80000000 -> alu_res=0xF0000000 (shift by 3).
- mulh with a=0xFFFFFFFE, b=3 -> out_valid at T+33, alu_res=0xFFFFFFFF. mulhu with the same operands -> alu_res=0x00000002.
- div with a=−7, b=2 -> alu_res=0xFFFFFFFD. rem with a=−7, b=2 -> alu_res=0xFFFFFFFF. divu with b=0 -> alu_res=0xFFFFFFFF at T+1. div with 0x80000000 / 0xFFFFFFFF -> alu_res=0x80000000 at T+1.
- Assert rst for one cycle at T+10 of a divu -> out_valid never rises for it. The next op accepted after reset returns the correct result.
- With XLEN=16, mul 0x1234 × 0x0100 -> alu_res=0x3400 at T+17. With EXU_MDU_EN undefined, any md_en op -> alu_res=0 at T+1.

Source files
------------

// File: rtl/exu_seq.sv
// rtl/exu_seq.sv - sequential execute unit: single-cycle ALU plus optional iterative RV32M multiply/divide
// Build option: define EXU_MDU_EN to compile in the multiply/divide datapath, its counter and the BUSY state.
// Ports:
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   in_valid / in_ready        operation handshake (accept when both high)
//   alu_srca, alu_srcb         operand A/B selects
//   alu_ctrl                   ALU operation
//   md_en, md_op               M-extension enable and operation
//   data_reg1, data_reg2       register source values
//   ext_imm, pc_val            immediate and pc source values
//   out_valid / out_ready      result handshake
//   alu_res                    registered result, held until taken
module exu_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_srca,
  input  logic [1:0]      alu_srcb,
  input  logic [3:0]      alu_ctrl,
  input  logic            md_en,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] data_reg1,
  input  logic [XLEN-1:0] data_reg2,
  input  logic [XLEN-1:0] ext_imm,
  input  logic [XLEN-1:0] pc_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_res
);

`ifdef EXU_MDU_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

  state_t state, state_nxt;
  logic   accept;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // ---------------- ALU ----------------
  logic [XLEN-1:0] opa, opb, alu_out;
  logic [SHW-1:0]  shamt;

  always_comb begin
    case (alu_srca)
      2'b00:   opa = data_reg1;
      2'b10:   opa = pc_val;
      default: opa = '0;
    endcase
    case (alu_srcb)
      2'b00:   opb = data_reg2;
      2'b01:   opb = ext_imm;
      2'b10:   opb = {{(XLEN-SHW){1'b0}}, data_reg2[SHW-1:0]};
      default: opb = '0;
    endcase
  end

  assign shamt = opb[SHW-1:0];

  always_comb begin
    case (alu_ctrl)
      4'd0:    alu_out = opa + opb;
      4'd1:    alu_out = opa - opb;
      4'd2:    alu_out = opa << shamt;
      4'd3:    alu_out = {{(XLEN-1){1'b0}}, $signed(opa) < $signed(opb)};
      4'd4:    alu_out = {{(XLEN-1){1'b0}}, opa < opb};
      4'd5:    alu_out = opa ^ opb;
      4'd6:    alu_out = opa >> shamt;
      4'd7:    alu_out = $signed(opa) >>> shamt;
      4'd8:    alu_out = opa | opb;
      4'd9:    alu_out = opa & opb;
      default: alu_out = '0;
    endcase
  end

`ifdef EXU_MDU_EN
  // ---------------- multiply / divide ----------------
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [2:0]        op_q;
  logic              neg_q;      // product sign, or quotient sign for divides
  logic              neg_r;      // remainder sign (follows the dividend)
  logic [XLEN-1:0]   opnd_q;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] prod_q;     // product, or {remainder, dividend/quotient}
  logic [CW-1:0]     cnt_q;

  logic              is_div, a_neg, b_neg, md_special;
  logic [XLEN-1:0]   mag_a, mag_b, special_res;

  always_comb begin
    is_div      = md_op[2];
    a_neg       = data_reg1[XLEN-1] & (is_div ? ~md_op[0] : (md_op == 3'd1 || md_op == 3'd2));
    b_neg       = data_reg2[XLEN-1] & (is_div ? ~md_op[0] : (md_op == 3'd1));
    mag_a       = a_neg ? -data_reg1 : data_reg1;
    mag_b       = b_neg ? -data_reg2 : data_reg2;
    md_special  = 1'b0;
    special_res = '0;
    if (is_div && data_reg2 == '0) begin
      md_special  = 1'b1;
      special_res = md_op[1] ? data_reg1 : '1;
    end else if (is_div && !md_op[0] && data_reg1 == MOST_NEG && data_reg2 == '1) begin
      md_special  = 1'b1;
      special_res = md_op[1] ? '0 : MOST_NEG;
    end
  end

  logic [XLEN:0]     mul_sum, div_try;
  logic [2*XLEN-1:0] step, signed_prod;
  logic [XLEN-1:0]   quo, rem, md_res;

  // One iteration per cycle; the final result is formed from the last
  // iteration's output so it lands in alu_res on the same edge the counter hits 0.
  always_comb begin
    mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    div_try = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]} - {1'b0, opnd_q};
    if (!op_q[2])
      step = {mul_sum, prod_q[XLEN-1:1]};
    else if (div_try[XLEN])
      step = {prod_q[2*XLEN-2:0], 1'b0};
    else
      step = {div_try[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    signed_prod = neg_q ? -step : step;
    quo         = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
    rem         = neg_r ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
    if (op_q[2])
      md_res = op_q[1] ? rem : quo;
    else
      md_res = (op_q[1:0] == 2'd0) ? signed_prod[XLEN-1:0] : signed_prod[2*XLEN-1:XLEN];
  end
`else
  logic unused_md;
  assign unused_md = ^md_op;
`endif

  // ---------------- control ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef EXU_MDU_EN
          state_nxt = (md_en && !md_special) ? BUSY : DONE;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef EXU_MDU_EN
      BUSY: if (cnt_q == CW'(1)) state_nxt = DONE;
`endif
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_res <= '0;
`ifdef EXU_MDU_EN
      op_q    <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      opnd_q  <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
`endif
    end else if (accept) begin
`ifdef EXU_MDU_EN
      if (!md_en) begin
        alu_res <= alu_out;
      end else if (md_special) begin
        alu_res <= special_res;
      end else begin
        op_q   <= md_op;
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        opnd_q <= is_div ? mag_b : mag_a;
        prod_q <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
        cnt_q  <= CW'(XLEN);
      end
`else
      alu_res <= md_en ? '0 : alu_out;
`endif
    end
`ifdef EXU_MDU_EN
    else if (state == BUSY) begin
      prod_q <= step;
      cnt_q  <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) alu_res <= md_res;
    end
`endif
  end

endmodule

// File: tb/tb_exu_seq.sv
// tb/tb_exu_seq.sv - directed self-checking bench for exu_seq
module tb_exu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, md_en, out_valid, out_ready;
  logic [1:0]  alu_srca, alu_srcb;
  logic [3:0]  alu_ctrl;
  logic [2:0]  md_op;
  logic [31:0] data_reg1, data_reg2, ext_imm, pc_val, alu_res;

  logic        in_valid16, in_ready16, md_en16, out_valid16, out_ready16;
  logic [2:0]  md_op16;
  logic [15:0] a16, b16, res16;

  int n_checks = 0;
  int n_fail   = 0;

  exu_seq #(.XLEN(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
    .md_en(md_en), .md_op(md_op), .data_reg1(data_reg1), .data_reg2(data_reg2),
    .ext_imm(ext_imm), .pc_val(pc_val), .out_valid(out_valid),
    .out_ready(out_ready), .alu_res(alu_res)
  );

  exu_seq #(.XLEN(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .alu_srca(2'b00), .alu_srcb(2'b00), .alu_ctrl(4'd0),
    .md_en(md_en16), .md_op(md_op16), .data_reg1(a16), .data_reg2(b16),
    .ext_imm(16'h0000), .pc_val(16'h0000), .out_valid(out_valid16),
    .out_ready(out_ready16), .alu_res(res16)
  );

  // ALU vectors: srca, srcb, ctrl, reg1, reg2, imm, pc, expected
  localparam int NALU = 14;
  logic [1:0]  va_sa  [NALU] = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
  logic [1:0]  va_sb  [NALU] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00};
  logic [3:0]  va_ctl [NALU] = '{4'd7, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd2, 4'd8, 4'd9, 4'd12, 4'd0, 4'd0, 4'd3, 4'd7};
  logic [31:0] va_r1  [NALU] = '{32'h80000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'h80000000,
                                 32'h00000001, 32'hF0F00000, 32'hFF00FF00, 32'h1234, 32'h1234, 32'h55, 32'h5, 32'h80000000};
  logic [31:0] va_r2  [NALU] = '{32'h23, 32'h10, 32'h1, 32'h1, 32'hFF00FF00, 32'h24,
                                 32'h3F, 32'h0000000F, 32'h0FF00FF0, 32'h5678, 32'h0, 32'h99, 32'hFFFFFFFB, 32'h21};
  logic [31:0] va_imm [NALU] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hABCD, 32'h0, 32'h0, 32'h0};
  logic [31:0] va_pc  [NALU] = '{32'h0, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [31:0] va_exp [NALU] = '{32'hF0000000, 32'hF0, 32'h1, 32'h0, 32'h0FF00FF0, 32'h08000000,
                                 32'h80000000, 32'hF0F0000F, 32'h0F000F00, 32'h0, 32'hABCD, 32'h55, 32'h0, 32'hC0000000};

  // MDU vectors: op, a, b, expected, latency
  localparam int NMD = 14;
  logic [2:0]  vm_op  [NMD] = '{3'd1, 3'd3, 3'd0, 3'd2, 3'd4, 3'd6, 3'd5, 3'd4, 3'd6, 3'd5, 3'd7, 3'd6, 3'd4, 3'd6};
  logic [31:0] vm_a   [NMD] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                32'd100, 32'h80000000, 32'h80000000, 32'd100, 32'd100, 32'hFFFFFFF9, 32'd7, 32'd7};
  logic [31:0] vm_b   [NMD] = '{32'd3, 32'd3, 32'd3, 32'd3, 32'd2, 32'd2, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'd7, 32'd7, 32'd0, 32'hFFFFFFFE, 32'hFFFFFFFE};
  logic [31:0] vm_exp [NMD] = '{32'hFFFFFFFF, 32'h2, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                32'hFFFFFFFF, 32'h80000000, 32'h0, 32'd14, 32'd2, 32'hFFFFFFF9, 32'hFFFFFFFD, 32'd1};
  int          vm_lat [NMD] = '{33, 33, 33, 33, 33, 33, 1, 1, 1, 33, 33, 1, 33, 33};

  // Presents one op for exactly one accept edge, then counts cycles until
  // out_valid (1 = the cycle right after the accept edge). -1 on timeout.
  task automatic run_op(input logic en, input logic [2:0] mop, input logic [1:0] sa, input logic [1:0] sb,
                        input logic [3:0] ctl, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] imm, input logic [31:0] pc, output int lat);
    @(negedge clk);
    in_valid = 1'b1; md_en = en; md_op = mop; alu_srca = sa; alu_srcb = sb; alu_ctrl = ctl;
    data_reg1 = r1; data_reg2 = r2; ext_imm = imm; pc_val = pc;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    data_reg1 = 32'hDEADBEEF; data_reg2 = 32'h0BADF00D;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      if (out_valid) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (alu_res !== 32'h0) begin n_fail++; $display("FAIL reset_alu_res: got %h expected 00000000", alu_res); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_alu_add_hold();
    int lat;
    run_op(1'b0, 3'd0, 2'b00, 2'b01, 4'd0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd0, lat);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d expected 1", lat); end
    n_checks++;
    if (alu_res !== 32'd4) begin n_fail++; $display("FAIL add_result: got %h expected 00000004", alu_res); end
    in_valid = 1'b1; data_reg1 = 32'd100; ext_imm = 32'd1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || alu_res !== 32'd4 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL add_hold cycle %0d: got valid=%b res=%h ready=%b expected 1/00000004/0",
                 c, out_valid, alu_res, in_ready);
      end
    end
    in_valid = 1'b0;
    take_result();
  endtask

  task automatic test_alu_ops();
    int lat;
    for (int i = 0; i < NALU; i++) begin
      run_op(1'b0, 3'd0, va_sa[i], va_sb[i], va_ctl[i], va_r1[i], va_r2[i], va_imm[i], va_pc[i], lat);
      n_checks++;
      if (lat !== 1 || alu_res !== va_exp[i]) begin
        n_fail++;
        $display("FAIL alu_vec %0d: got lat=%0d res=%h expected lat=1 res=%h", i, lat, alu_res, va_exp[i]);
      end
      take_result();
    end
  endtask

  task automatic test_mdu();
    int lat;
`ifdef EXU_MDU_EN
    for (int i = 0; i < NMD; i++) begin
      run_op(1'b1, vm_op[i], 2'b10, 2'b01, 4'd1, vm_a[i], vm_b[i], 32'h7, 32'h9, lat);
      n_checks++;
      if (lat !== vm_lat[i] || alu_res !== vm_exp[i]) begin
        n_fail++;
        $display("FAIL mdu_vec %0d: got lat=%0d res=%h expected lat=%0d res=%h",
                 i, lat, alu_res, vm_lat[i], vm_exp[i]);
      end
      take_result();
    end
`else
    for (int i = 0; i < 3; i++) begin
      run_op(1'b1, vm_op[i*4], 2'b00, 2'b00, 4'd0, 32'd3, 32'd5, 32'd0, 32'd0, lat);
      n_checks++;
      if (lat !== 1 || alu_res !== 32'h0) begin
        n_fail++;
        $display("FAIL md_disabled %0d: got lat=%0d res=%h expected lat=1 res=00000000", i, lat, alu_res);
      end
      take_result();
    end
`endif
  endtask

  task automatic test_reset_abort();
    int lat;
    bit seen;
    @(negedge clk);
    in_valid = 1'b1; alu_srca = 2'b00; alu_srcb = 2'b00; alu_ctrl = 4'd0;
    data_reg1 = 32'd100; data_reg2 = 32'd7; md_op = 3'd5;
`ifdef EXU_MDU_EN
    md_en = 1'b1;
`else
    md_en = 1'b0;
`endif
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_in_ready_in_rst: got %b expected 0", in_ready); end
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_result: got out_valid seen=%b expected 0", seen); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready_after: got %b expected 1", in_ready); end
    run_op(1'b0, 3'd0, 2'b00, 2'b00, 4'd0, 32'd7, 32'd8, 32'd0, 32'd0, lat);
    n_checks++;
    if (lat !== 1 || alu_res !== 32'd15) begin
      n_fail++;
      $display("FAIL abort_next_op: got lat=%0d res=%h expected lat=1 res=0000000f", lat, alu_res);
    end
    take_result();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_ready: got %b expected 1", in_ready); end
    in_valid = 1'b1; out_ready = 1'b1; md_en = 1'b0; alu_srca = 2'b00; alu_srcb = 2'b00; alu_ctrl = 4'd0;
    data_reg1 = 32'd1; data_reg2 = 32'd2;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_res !== 32'd3) begin
      n_fail++;
      $display("FAIL b2b_first: got valid=%b ready=%b res=%h expected 1/0/00000003", out_valid, in_ready, alu_res);
    end
    data_reg1 = 32'd10; data_reg2 = 32'd20;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_gap: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || alu_res !== 32'd30) begin
      n_fail++;
      $display("FAIL b2b_second: got valid=%b res=%h expected 1/0000001e", out_valid, alu_res);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_xlen16();
    int lat;
    @(negedge clk);
    in_valid16 = 1'b1; md_en16 = 1'b1; md_op16 = 3'd0; a16 = 16'h1234; b16 = 16'h0100;
    @(posedge clk);
    @(negedge clk);
    in_valid16 = 1'b0; a16 = 16'hFFFF; b16 = 16'hFFFF;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (out_valid16) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
`ifdef EXU_MDU_EN
    n_checks++;
    if (lat !== 17 || res16 !== 16'h3400) begin
      n_fail++;
      $display("FAIL xlen16_mul: got lat=%0d res=%h expected lat=17 res=3400", lat, res16);
    end
`else
    n_checks++;
    if (lat !== 1 || res16 !== 16'h0000) begin
      n_fail++;
      $display("FAIL xlen16_md_disabled: got lat=%0d res=%h expected lat=1 res=0000", lat, res16);
    end
`endif
    out_ready16 = 1'b1;
    @(negedge clk);
    out_ready16 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; md_en = 1'b0; md_op = 3'd0; out_ready = 1'b0;
    alu_srca = 2'b00; alu_srcb = 2'b00; alu_ctrl = 4'd0;
    data_reg1 = '0; data_reg2 = '0; ext_imm = '0; pc_val = '0;
    in_valid16 = 1'b0; md_en16 = 1'b0; md_op16 = 3'd0; out_ready16 = 1'b0; a16 = '0; b16 = '0;

    test_reset();
    test_alu_add_hold();
    test_alu_ops();
    test_mdu();
    test_reset_abort();
    test_back_to_back();
    test_xlen16();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
